// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to a req/ack instruction memory and
// feeds IF/ID, with a one-entry skid buffer to survive hazard stalls.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hd_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        jump_i,
    input  logic [25:0] jump_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] inst_addr_o,
    output logic [31:0] inst_o,
    output logic        valid_o,
    output logic        flush_o
);

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_DRAIN,
        ST_HOLD
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_p0;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;
    logic        pend_p1;
    logic [31:0] req_addr_p1;
    logic [31:0] skid_inst_p1;
    logic [31:0] skid_addr_p1;

    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ack_v;
    logic        load_out;
    logic        load_skid;
    logic        pop_skid;
    logic        bubble;

    assign pc_plus4    = pc_p0 + 32'd4;
    assign redirect    = branch_i | jump_i;
    assign redirect_pc = branch_i ? (branch_addr_i & ~32'h3)
                                  : {pc_plus4[31:28], jump_addr_i, 2'b00};
    // An ack only counts against a request we are actually driving.
    assign ack_v       = imem_ack_i & imem_req_o;

    always_comb begin
        imem_req_o  = 1'b0;
        imem_addr_o = pc_p0;
        case (state_q)
            ST_FETCH: imem_req_o = pend_p1 | ~hd_i;
            ST_DRAIN: begin
                imem_req_o  = 1'b1;
                imem_addr_o = req_addr_p1;
            end
            default: imem_req_o = 1'b0;
        endcase
        if (rst_i) begin
            imem_req_o = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_p0;
        load_out  = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        bubble    = 1'b0;
        if (redirect) begin
            pc_d    = redirect_pc;
            bubble  = 1'b1;
            state_d = (imem_req_o && !ack_v) ? ST_DRAIN : ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (ack_v) begin
                        pc_d = pc_plus4;
                        if (hd_i) begin
                            load_skid = 1'b1;
                            state_d   = ST_HOLD;
                        end else begin
                            load_out = 1'b1;
                        end
                    end else if (!hd_i) begin
                        bubble = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!hd_i) begin
                        pop_skid = 1'b1;
                        state_d  = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (ack_v) begin
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    // Control and IF/ID-facing registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_FETCH;
            pc_p0       <= RESET_PC;
            pend_p1     <= 1'b0;
            inst_o      <= NOP_INST;
            inst_addr_o <= 32'h0;
            valid_o     <= 1'b0;
            flush_o     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_p0   <= pc_d;
            pend_p1 <= imem_req_o & ~ack_v;
            flush_o <= redirect;
            if (load_out) begin
                inst_o      <= imem_data_i;
                inst_addr_o <= pc_plus4;
                valid_o     <= 1'b1;
            end else if (pop_skid) begin
                inst_o      <= skid_inst_p1;
                inst_addr_o <= skid_addr_p1;
                valid_o     <= 1'b1;
            end else if (bubble) begin
                inst_o  <= NOP_INST;
                valid_o <= 1'b0;
            end
        end
    end

    // Datapath-only registers; their contents are qualified by state_q
    always_ff @(posedge clk_i) begin
        if (imem_req_o) begin
            req_addr_p1 <= imem_addr_o;
        end
        if (load_skid) begin
            skid_inst_p1 <= imem_data_i;
            skid_addr_p1 <= pc_plus4;
        end
    end

endmodule
